// File: rtl/traffic_lights_cfg_seq.sv
// Request-to-command sequencer for traffic_lights; optional skipping of unchanged
// periods is enabled by defining TL_CFG_SKIP_UNCHANGED_EN.
module traffic_lights_cfg_seq #(
    parameter int unsigned CMD_GAP_CYCLES = 2,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned DEFAULT_PERIOD = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [DATA_W-1:0] req_green_i,
    input  logic [DATA_W-1:0] req_red_i,
    input  logic [DATA_W-1:0] req_yellow_i,
    output logic [2:0]        cmd_type_o,
    output logic              cmd_valid_o,
    output logic [DATA_W-1:0] cmd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] shadow_green_o,
    output logic [DATA_W-1:0] shadow_red_o,
    output logic [DATA_W-1:0] shadow_yellow_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

    localparam int unsigned CW = (CMD_GAP_CYCLES > 1) ? $clog2(CMD_GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD =
        CW'((CMD_GAP_CYCLES > 0) ? CMD_GAP_CYCLES - 1 : 0);
    localparam logic [DATA_W-1:0] DEF = DATA_W'(DEFAULT_PERIOD);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        pend_q, pend_d;
    logic              off_q, off_d;
    logic [DATA_W-1:0] g_q, g_d, r_q, r_d, y_q, y_d;
    logic [DATA_W-1:0] shg_q, shg_d, shr_q, shr_d, shy_q, shy_d;
    logic              done_q, done_d, err_q, err_d;

    logic [2:0]        slot;
    logic [4:0]        pend_rest;
    logic [2:0]        typ;
    logic [DATA_W-1:0] dat;
    logic              accept, bad;
    logic [2:0]        chg;

    assign req_ready_o = rst_n_i & (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign cmd_valid_o = (state_q == ISSUE);
    assign cmd_type_o  = cmd_valid_o ? typ : 3'd0;
    assign cmd_data_o  = cmd_valid_o ? dat : '0;

    assign shadow_green_o  = shg_q;
    assign shadow_red_o    = shr_q;
    assign shadow_yellow_o = shy_q;

    assign accept = req_valid_i & req_ready_o;
    assign bad    = (req_op_i == 2'd3) |
                    ((req_op_i == 2'd0) &
                     ((req_green_i == '0) | (req_red_i == '0) | (req_yellow_i == '0)));

`ifdef TL_CFG_SKIP_UNCHANGED_EN
    assign chg = {req_yellow_i != shy_q, req_red_i != shr_q, req_green_i != shg_q};
`else
    assign chg = 3'b111;
`endif

    // Slots in issue order: 0=no-transition, 1..3=G/R/Y, 4=on/off.
    always_comb begin
        slot = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend_q[i]) slot = 3'(i);
        end
    end

    assign pend_rest = pend_q & ~(5'b00001 << slot);

    always_comb begin
        typ = 3'd0;
        dat = '0;
        unique case (slot)
            3'd0: typ = 3'd2;
            3'd1: begin typ = 3'd3; dat = g_q; end
            3'd2: begin typ = 3'd4; dat = r_q; end
            3'd3: begin typ = 3'd5; dat = y_q; end
            default: typ = off_q ? 3'd1 : 3'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        off_d   = off_q;
        g_d     = g_q;
        r_d     = r_q;
        y_d     = y_q;
        shg_d   = shg_q;
        shr_d   = shr_q;
        shy_d   = shy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d = (req_op_i == 2'd1);
                    g_d   = req_green_i;
                    r_d   = req_red_i;
                    y_d   = req_yellow_i;
                    if (bad) begin
                        err_d = 1'b1;
                    end else if (req_op_i != 2'd0) begin
                        pend_d  = 5'b10000;
                        state_d = ISSUE;
                    end else if (chg == 3'b000) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = {1'b1, chg, 1'b1};
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                pend_d = pend_rest;
                unique case (slot)
                    3'd1:    shg_d = g_q;
                    3'd2:    shr_d = r_q;
                    3'd3:    shy_d = y_q;
                    default: ;
                endcase
                if (pend_rest == 5'b00000) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (CMD_GAP_CYCLES == 0) begin
                    state_d = ISSUE;
                end else begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = ISSUE;
                else cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            off_q   <= 1'b0;
            g_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
            shg_q   <= DEF;
            shr_q   <= DEF;
            shy_q   <= DEF;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            off_q   <= off_d;
            g_q     <= g_d;
            r_q     <= r_d;
            y_q     <= y_d;
            shg_q   <= shg_d;
            shr_q   <= shr_d;
            shy_q   <= shy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
